// File: rtl/ser_tx_pkg.sv
// rtl/ser_tx_pkg.sv - shared state encoding and constants for ser_tx_sched (SER_TX_SCHED_PARITY_EN adds PARITY)
package ser_tx_pkg;

    localparam int DIV_MIN_DEF = 2;
    localparam int DATA_BITS   = 8;

    // Explicit codes keep IDLE..STOP stable whether or not PARITY exists.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef SER_TX_SCHED_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/ser_tx_shift.sv
// rtl/ser_tx_shift.sv - shift register, baud and bit counters for one frame (SER_TX_SCHED_PARITY_EN adds parity bit)
module ser_tx_shift
    import ser_tx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  data,
    input  logic [31:0] div,
    input  logic [2:0]  state,
    output logic        ser_tx,
    output logic        done
);

    logic [31:0] div_q;
    logic [31:0] baud_cnt;
    logic [7:0]  shreg;
    logic [2:0]  bit_cnt;
    logic        baud_zero;
`ifdef SER_TX_SCHED_PARITY_EN
    logic        par_q;
`endif

    assign baud_zero = (baud_cnt == 32'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= 32'd0;
            baud_cnt <= 32'd0;
            shreg    <= 8'd0;
            bit_cnt  <= 3'd0;
        end else if (load) begin
            div_q    <= div;
            baud_cnt <= div - 32'd1;
            shreg    <= data;
            bit_cnt  <= 3'd0;
        end else if (state != ST_IDLE) begin
            if (baud_zero) begin
                baud_cnt <= div_q - 32'd1;
                if (state == ST_DATA) begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else begin
                baud_cnt <= baud_cnt - 32'd1;
            end
        end
    end

`ifdef SER_TX_SCHED_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= ^data;
        end
    end
`endif

    // DATA only completes after the last of its bits has run its full period.
    assign done = (state != ST_IDLE) && baud_zero &&
                  ((state != ST_DATA) || (bit_cnt == 3'(DATA_BITS - 1)));

    always_comb begin
        ser_tx = 1'b1;
        case (state)
            ST_START:  ser_tx = 1'b0;
            ST_DATA:   ser_tx = shreg[0];
`ifdef SER_TX_SCHED_PARITY_EN
            ST_PARITY: ser_tx = par_q;
`endif
            default:   ser_tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/ser_tx_sched.sv
// rtl/ser_tx_sched.sv - round-robin byte arbiter driving a UART-style serial line (SER_TX_SCHED_PARITY_EN adds parity)
module ser_tx_sched
    import ser_tx_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DIV_MIN = DIV_MIN_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         cfg_div,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic [1:0]          grant_id,
    output logic                busy,
    output logic                ser_tx
);

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  last_grant;
    logic [1:0]  pick_idx;
    logic        pick_found;
    logic [3:0]  valid_pad;
    logic [2:0]  cand;
    logic [7:0]  data_sel;
    logic [31:0] div_eff;
    logic        accept;
    logic        shift_done;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        valid_pad  = 4'(req_valid);
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        cand       = 3'd0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_grant} + 3'(k);
            if (cand >= 3'(NREQ)) begin
                cand = cand - 3'(NREQ);
            end
            if (!pick_found && valid_pad[cand[1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[1:0];
            end
        end
    end

    assign accept = (state_q == ST_IDLE) && !reset && pick_found;

    always_comb begin
        req_ready = '0;
        data_sel  = 8'd0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (pick_idx == 2'(i));
            if (pick_idx == 2'(i)) begin
                data_sel = req_data[8*i +: 8];
            end
        end
    end

    assign div_eff = (cfg_div < 32'(DIV_MIN)) ? 32'(DIV_MIN) : cfg_div;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept)     state_d = ST_START;
            ST_START:  if (shift_done) state_d = ST_DATA;
`ifdef SER_TX_SCHED_PARITY_EN
            ST_DATA:   if (shift_done) state_d = ST_PARITY;
            ST_PARITY: if (shift_done) state_d = ST_STOP;
`else
            ST_DATA:   if (shift_done) state_d = ST_STOP;
`endif
            ST_STOP:   if (shift_done) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_grant <= 2'(NREQ - 1);
            grant_id   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant <= pick_idx;
                grant_id   <= pick_idx;
            end
        end
    end

    assign busy = (state_q != ST_IDLE);

    ser_tx_shift u_shift (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .data   (data_sel),
        .div    (div_eff),
        .state  (state_q),
        .ser_tx (ser_tx),
        .done   (shift_done)
    );

endmodule

// File: tb/tb_ser_tx_sched.sv
// tb/tb_ser_tx_sched.sv - directed vector bench for ser_tx_sched (honours SER_TX_SCHED_PARITY_EN)
module tb_ser_tx_sched;

`ifdef SER_TX_SCHED_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cfg_div;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic [1:0]  grant_id;
    logic        busy;
    logic        ser_tx;

    int total = 0;
    int bad   = 0;
    string cur = "init";

    typedef struct {
        logic [31:0] div;
        logic        mid_en;
        logic [31:0] mid_div;
        logic [1:0]  valid;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic        drop;
        logic        b2b;
        logic [1:0]  g;
        logic [7:0]  dat;
        int          ediv;
    } vec_t;

    vec_t vecs[10];
    vec_t rv;

    ser_tx_sched #(.NREQ(2), .DIV_MIN(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_div   (cfg_div),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .ser_tx    (ser_tx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got %0h expected %0h", cur, name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef SER_TX_SCHED_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    function automatic vec_t mk(input logic [31:0] div, input logic mid_en, input logic [31:0] mid_div,
                                input logic [1:0] valid, input logic [7:0] d0, input logic [7:0] d1,
                                input logic drop, input logic b2b, input logic [1:0] g,
                                input logic [7:0] dat, input int ediv);
        vec_t v;
        v.div = div; v.mid_en = mid_en; v.mid_div = mid_div; v.valid = valid;
        v.d0 = d0; v.d1 = d1; v.drop = drop; v.b2b = b2b; v.g = g; v.dat = dat; v.ediv = ediv;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int n;
        int bc;
        logic ok_bit, ok_gid, ok_rdy;
        logic [10:0] sam;
        logic [1:0] exp_rdy;
        cfg_div   = v.div;
        req_valid = v.valid;
        req_data  = {v.d1, v.d0};
        exp_rdy   = 2'b01 << v.g;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("ready", {30'd0, req_ready}, {30'd0, exp_rdy});
        if (v.b2b) chk("gap", n, 0);
        if (req_ready == 2'b00) return;
        ok_gid = 1'b1;
        ok_rdy = 1'b1;
        bc = 0;
        sam = '0;
        for (int b = 0; b < NBITS; b++) begin
            ok_bit = 1'b1;
            for (int c = 0; c < v.ediv; c++) begin
                @(negedge clk);
                if (b == 0 && c == 0) begin
                    if (v.drop) req_valid = 2'b00;
                    if (v.mid_en) cfg_div = v.mid_div;
                end
                if (ser_tx !== exp_bit(v.dat, b)) ok_bit = 1'b0;
                if (busy === 1'b1) bc++;
                if (grant_id !== v.g) ok_gid = 1'b0;
                if (req_ready !== 2'b00) ok_rdy = 1'b0;
                if (c == v.ediv / 2) sam[b] = ser_tx;
            end
            chk($sformatf("bit%0d", b), {31'd0, ok_bit}, 32'd1);
        end
        chk("frame_len", bc, NBITS * v.ediv);
        chk("grant_id", {31'd0, ok_gid}, 32'd1);
        chk("ready_low", {31'd0, ok_rdy}, 32'd1);
        chk("decode", {24'd0, sam[8:1]}, {24'd0, v.dat});
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_tx", {31'd0, ser_tx}, 32'd1);
    endtask

    initial begin
        //          div  mid  mid_div valid d0     d1     drop b2b g     dat    ediv
        vecs[0] = mk(106, 0, 0,  2'b11, 8'h41, 8'h99, 1, 0, 2'd0, 8'h41, 106);
        vecs[1] = mk(0,   0, 0,  2'b10, 8'h00, 8'h5A, 1, 0, 2'd1, 8'h5A, 2);
        vecs[2] = mk(1,   0, 0,  2'b11, 8'hC3, 8'h3C, 1, 0, 2'd0, 8'hC3, 2);
        vecs[3] = mk(3,   0, 0,  2'b10, 8'h00, 8'h07, 1, 0, 2'd1, 8'h07, 3);
        vecs[4] = mk(5,   0, 0,  2'b11, 8'h30, 8'h31, 0, 0, 2'd0, 8'h30, 5);
        vecs[5] = mk(5,   0, 0,  2'b11, 8'h30, 8'h31, 0, 1, 2'd1, 8'h31, 5);
        vecs[6] = mk(5,   0, 0,  2'b11, 8'h30, 8'h31, 0, 1, 2'd0, 8'h30, 5);
        vecs[7] = mk(5,   0, 0,  2'b11, 8'h30, 8'h31, 1, 1, 2'd1, 8'h31, 5);
        vecs[8] = mk(106, 1, 50, 2'b01, 8'h03, 8'h00, 1, 0, 2'd0, 8'h03, 106);
        vecs[9] = mk(50,  0, 0,  2'b10, 8'h00, 8'hA5, 1, 0, 2'd1, 8'hA5, 50);

        reset     = 1'b1;
        cfg_div   = 32'd106;
        req_valid = 2'b00;
        req_data  = 16'h0000;
        repeat (3) @(negedge clk);
        cur = "reset";
        chk("ser_tx", {31'd0, ser_tx}, 32'd1);
        chk("busy", {31'd0, busy}, 32'd0);
        chk("grant_id", {30'd0, grant_id}, 32'd0);
        req_valid = 2'b11;
        #1;
        chk("ready_in_reset", {30'd0, req_ready}, 32'd0);
        reset     = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            cur = $sformatf("vec%0d", i);
            run_vec(vecs[i]);
        end

        // Reset during data bit 3 of a req0 frame (div 4: bit 3 spans N17..N20).
        cur = "midreset";
        cfg_div   = 32'd4;
        req_valid = 2'b01;
        req_data  = {8'h00, 8'hF0};
        #1;
        begin
            int n;
            n = 0;
            while (req_ready == 2'b00 && n < 40) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        chk("ready", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (17) @(negedge clk);
        chk("pre_tx", {31'd0, ser_tx}, 32'd0);
        chk("pre_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("tx", {31'd0, ser_tx}, 32'd1);
        chk("busy", {31'd0, busy}, 32'd0);
        req_valid = 2'b11;
        #1;
        chk("ready_in_reset", {30'd0, req_ready}, 32'd0);
        reset = 1'b0;
        cur = "postreset";
        rv = mk(4, 0, 0, 2'b11, 8'h12, 8'h34, 1, 0, 2'd0, 8'h12, 4);
        run_vec(rv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
